// File: rtl/atm_dispensador_billetes.sv
// Cash-dispenser sequencer: greedy all-or-nothing bill planning against
// cassette inventory, then one-bill-at-a-time feed over listo/hecho.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   entregar_dinero     start pulse; monto is sampled with it (IDLE only)
//   monto               requested amount in colones
//   recarga             reload every cassette to CAPACIDAD (IDLE only)
//   mecanismo_listo     mechanism can take a bill
//   mecanismo_hecho     mechanism acknowledges a delivered bill
//   ocupado             high whenever the sequencer is not idle
//   expulsar_billete    one-cycle eject command, cassette on denominacion
//   dispensado_ok       one-cycle pulse: whole amount delivered
//   fallo               one-cycle pulse: rejected or aborted
//   codigo_fallo        cause of the last failure, held until next start
//   inventario_bajo     per-cassette low-inventory flags
module atm_dispensador_billetes #(
  parameter int D0           = 20000,
  parameter int D1           = 10000,
  parameter int D2           = 5000,
  parameter int D3           = 2000,
  parameter int D4           = 1000,
  parameter int CAP_W        = 8,
  parameter int CAPACIDAD    = 100,
  parameter int UMBRAL_BAJO  = 10,
  parameter int MAX_BILLETES = 40,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entregar_dinero,
  input  logic [31:0] monto,
  input  logic        recarga,
  input  logic        mecanismo_listo,
  input  logic        mecanismo_hecho,
  output logic        ocupado,
  output logic        expulsar_billete,
  output logic [2:0]  denominacion,
  output logic        dispensado_ok,
  output logic        fallo,
  output logic [2:0]  codigo_fallo,
  output logic [4:0]  inventario_bajo
);

  localparam int TOT_W = $clog2(MAX_BILLETES + 1);
  localparam int TM_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] COD_CERO = 3'b001;
  localparam logic [2:0] COD_MAX  = 3'b010;
  localparam logic [2:0] COD_INF  = 3'b011;
  localparam logic [2:0] COD_TMO  = 3'b100;

  typedef enum logic [2:0] {
    IDLE, PLAN, SOLICITAR, EXPULSA, ESPERA, FIN, ERROR_MEC
  } state_t;

  state_t             state;
  logic [CAP_W-1:0]   inv  [5];
  logic [CAP_W-1:0]   plan [5];
  logic [31:0]        rem;
  logic [2:0]         d;
  logic [TOT_W-1:0]   total;
  logic [TM_W-1:0]    timer;

  function automatic logic [31:0] valor(input logic [2:0] i);
    case (i)
      3'd0:    valor = 32'(D0);
      3'd1:    valor = 32'(D1);
      3'd2:    valor = 32'(D2);
      3'd3:    valor = 32'(D3);
      default: valor = 32'(D4);
    endcase
  endfunction

  logic ultimo;
  logic vencido;
  logic tomar;

  assign ultimo  = (d == 3'd4);
  assign vencido = (timer == TM_W'(TIMEOUT - 1));
  // A bill can be taken only while the cassette still covers the plan.
  assign tomar   = (rem >= valor(d)) && (plan[d] < inv[d]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      rem              <= '0;
      d                <= '0;
      total            <= '0;
      timer            <= '0;
      ocupado          <= 1'b0;
      expulsar_billete <= 1'b0;
      denominacion     <= '0;
      dispensado_ok    <= 1'b0;
      fallo            <= 1'b0;
      codigo_fallo     <= '0;
      inventario_bajo  <= {5{CAPACIDAD < UMBRAL_BAJO}};
      for (int i = 0; i < 5; i++) begin
        inv[i]  <= CAP_W'(CAPACIDAD);
        plan[i] <= '0;
      end
    end else begin
      expulsar_billete <= 1'b0;
      dispensado_ok    <= 1'b0;
      fallo            <= 1'b0;
      for (int i = 0; i < 5; i++)
        inventario_bajo[i] <= inv[i] < CAP_W'(UMBRAL_BAJO);

      case (state)
        IDLE: begin
          if (recarga)
            for (int i = 0; i < 5; i++)
              inv[i] <= CAP_W'(CAPACIDAD);
          if (entregar_dinero) begin
            rem          <= monto;
            d            <= '0;
            total        <= '0;
            codigo_fallo <= '0;
            for (int i = 0; i < 5; i++)
              plan[i] <= '0;
            if (monto == 32'd0) begin
              fallo        <= 1'b1;
              codigo_fallo <= COD_CERO;
            end else begin
              state   <= PLAN;
              ocupado <= 1'b1;
            end
          end
        end

        PLAN: begin
          if (tomar) begin
            if (total == TOT_W'(MAX_BILLETES)) begin
              fallo        <= 1'b1;
              codigo_fallo <= COD_MAX;
              state        <= IDLE;
              ocupado      <= 1'b0;
            end else begin
              plan[d] <= plan[d] + 1'b1;
              rem     <= rem - valor(d);
              total   <= total + 1'b1;
            end
          end else if (!ultimo) begin
            d <= d + 3'd1;
          end else if (rem == 32'd0) begin
            d     <= '0;
            timer <= '0;
            state <= SOLICITAR;
          end else begin
            fallo        <= 1'b1;
            codigo_fallo <= COD_INF;
            state        <= IDLE;
            ocupado      <= 1'b0;
          end
        end

        SOLICITAR: begin
          if (plan[d] == '0) begin
            if (ultimo) begin
              dispensado_ok <= 1'b1;
              state         <= FIN;
            end else begin
              d <= d + 3'd1;
            end
          end else if (mecanismo_listo) begin
            expulsar_billete <= 1'b1;
            denominacion     <= d;
            state            <= EXPULSA;
          end else if (vencido) begin
            fallo        <= 1'b1;
            codigo_fallo <= COD_TMO;
            state        <= ERROR_MEC;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        EXPULSA: begin
          timer <= '0;
          state <= ESPERA;
        end

        ESPERA: begin
          if (mecanismo_hecho) begin
            inv[d]  <= inv[d] - 1'b1;
            plan[d] <= plan[d] - 1'b1;
            timer   <= '0;
            state   <= SOLICITAR;
          end else if (vencido) begin
            fallo        <= 1'b1;
            codigo_fallo <= COD_TMO;
            state        <= ERROR_MEC;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        FIN: begin
          state   <= IDLE;
          ocupado <= 1'b0;
        end

        // Stuck until reset; delivered bills stay deducted.
        ERROR_MEC: begin
          state <= ERROR_MEC;
        end

        default: begin
          state   <= IDLE;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
